// File: rtl/rate_map_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : rate_map_scheduler_if
// Frame input, mapper side-channel and code output bundle for the scheduler.
// Rev    : 1.0
// ============================================================================
interface rate_map_scheduler_if #(
    parameter int N_CH   = 4,
    parameter int RATE_W = 3
);
    localparam int c_ch_w = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                   frame_valid;
    logic [N_CH*RATE_W-1:0] frame_rates;
    logic                   in_ready;
    logic [RATE_W-1:0]      map_rate_in;
    logic [RATE_W-1:0]      map_max_rate;
    logic [RATE_W-1:0]      map_rate_out;
    logic                   code_valid;
    logic [RATE_W-1:0]      code;
    logic [c_ch_w-1:0]      code_ch;
    logic                   code_ready;
    logic                   mode_update;

    modport slave (
        input  frame_valid, frame_rates, map_rate_out, code_ready,
        output in_ready, map_rate_in, map_max_rate, code_valid, code, code_ch, mode_update
    );

    modport master (
        output frame_valid, frame_rates, map_rate_out, code_ready,
        input  in_ready, map_rate_in, map_max_rate, code_valid, code, code_ch, mode_update
    );
endinterface
`default_nettype wire

// File: rtl/rate_map_scheduler.sv
`default_nettype none
// ============================================================================
// Module : rate_map_scheduler
// Shares one combinational mapper across N_CH channels per frame and rebuilds
// per-channel histogram modes every WINDOW frames.
// Rev    : 1.0
// ============================================================================
module rate_map_scheduler #(
    parameter int N_CH   = 4,
    parameter int RATE_W = 3,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    rate_map_scheduler_if.slave  bus
);
    localparam int                c_ch_w       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int                c_fc_w       = $clog2(WINDOW);
    localparam int                c_n_bins     = 5;
    localparam logic [c_ch_w-1:0] c_last_ch    = c_ch_w'(N_CH - 1);
    localparam logic [c_fc_w-1:0] c_last_frame = c_fc_w'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MAP    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [RATE_W-1:0] r_rates [N_CH];
    logic [RATE_W-1:0] r_mode  [N_CH];
    logic [CNT_W-1:0]  r_hist  [N_CH][c_n_bins];
    logic [c_ch_w-1:0] r_ch;
    logic [c_fc_w-1:0] r_frame_cnt;
    logic [RATE_W-1:0] r_map_rate_in;
    logic [RATE_W-1:0] r_map_max_rate;
    logic              r_mode_update;

    logic              w_accept;
    logic              w_handshake;
    logic              w_last_ch;
    logic [c_ch_w-1:0] w_ch_nxt;
    logic [2:0]        w_bin;
    logic [2:0]        w_argmax;
    logic [CNT_W-1:0]  w_best;

    assign w_accept    = (r_state == ST_IDLE) && bus.frame_valid;
    assign w_handshake = (r_state == ST_MAP) && bus.code_ready;
    assign w_last_ch   = (r_ch == c_last_ch);
    assign w_ch_nxt    = r_ch + c_ch_w'(1);
    assign w_bin       = (r_map_rate_in > RATE_W'(4)) ? 3'd4 : 3'(r_map_rate_in);

    assign bus.map_rate_in  = r_map_rate_in;
    assign bus.map_max_rate = r_map_max_rate;
    assign bus.code         = bus.map_rate_out;
    assign bus.code_ch      = r_ch;
    assign bus.mode_update  = r_mode_update;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.in_ready   = 1'b0;
        bus.code_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.frame_valid) begin
                    w_state_nxt = ST_MAP;
                end
            end
            ST_MAP: begin
                bus.code_valid = 1'b1;
                if (bus.code_ready && w_last_ch) begin
                    w_state_nxt = (r_frame_cnt == c_last_frame) ? ST_UPDATE : ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (w_last_ch) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest bin index on ties.
    always_comb begin
        w_argmax = 3'd0;
        w_best   = r_hist[r_ch][0];
        for (int b = 1; b < c_n_bins; b++) begin
            if (r_hist[r_ch][b] > w_best) begin
                w_best   = r_hist[r_ch][b];
                w_argmax = 3'(b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_rates[c] <= '0;
                r_mode[c]  <= '0;
                for (int b = 0; b < c_n_bins; b++) begin
                    r_hist[c][b] <= '0;
                end
            end
            r_ch           <= '0;
            r_frame_cnt    <= '0;
            r_map_rate_in  <= '0;
            r_map_max_rate <= '0;
            r_mode_update  <= 1'b0;
        end else begin
            r_mode_update <= 1'b0;

            if (w_accept) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_rates[c] <= bus.frame_rates[c*RATE_W +: RATE_W];
                end
                r_ch           <= '0;
                r_map_rate_in  <= bus.frame_rates[RATE_W-1:0];
                r_map_max_rate <= r_mode[0];
            end

            if (w_handshake) begin
                if (r_hist[r_ch][w_bin] != '1) begin
                    r_hist[r_ch][w_bin] <= r_hist[r_ch][w_bin] + CNT_W'(1);
                end
                if (w_last_ch) begin
                    r_ch        <= '0;
                    r_frame_cnt <= (r_frame_cnt == c_last_frame) ? '0 : r_frame_cnt + c_fc_w'(1);
                end else begin
                    r_ch           <= w_ch_nxt;
                    r_map_rate_in  <= r_rates[w_ch_nxt];
                    r_map_max_rate <= r_mode[w_ch_nxt];
                end
            end

            if (r_state == ST_UPDATE) begin
                r_mode[r_ch] <= RATE_W'(w_argmax);
                for (int b = 0; b < c_n_bins; b++) begin
                    r_hist[r_ch][b] <= '0;
                end
                if (w_last_ch) begin
                    r_ch          <= '0;
                    r_mode_update <= 1'b1;
                end else begin
                    r_ch <= w_ch_nxt;
                end
            end
        end
    end
endmodule
`default_nettype wire
